oq_regs_host_proc: RTL and testbench

Executes host register accesses to the output-queue per-queue register file. It sits directly downstream of the OQ host-interface stage. That stage latches a decoded request and holds `req_in_progress` high. This block arbitrates with the datapath for the shared register-file port, performs the read or write, and returns `reg_result` with a one-cycle `result_ready` pulse, which releases the upstream stage.

---
 rtl/oq_regs_host_proc.sv | 106 ++++++++++
 tb/tb_oq_regs_host_proc.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/oq_regs_host_proc.sv
// Host register access engine for the output-queue per-queue register file.
// Arbitrates with the datapath for the shared port, then performs one read or write per held request.
module oq_regs_host_proc #(
  parameter int NUM_OUTPUT_QUEUES = 8,
  parameter int NUM_OQ_WIDTH      = 3,
  parameter int NUM_REGS_USED     = 17,
  parameter int ADDR_WIDTH        = 5,
  parameter int NUM_RO_REGS       = 8,
  parameter int MAX_WAIT          = 255
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              req_in_progress,
  input  logic                              reg_rd_wr_L_held,
  input  logic [31:0]                       reg_data_held,
  input  logic [ADDR_WIDTH-1:0]             addr,
  input  logic [NUM_OQ_WIDTH-1:0]           q_addr,
  output logic                              result_ready,
  output logic [31:0]                       reg_result,
  input  logic                              dp_busy,
  output logic                              rf_rd_en,
  output logic                              rf_wr_en,
  output logic [NUM_OQ_WIDTH+ADDR_WIDTH-1:0] rf_addr,
  output logic [31:0]                       rf_wr_data,
  input  logic [31:0]                       rf_rd_data
);

  localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [31:0] BAD_ACCESS = 32'hdead_beef;

  typedef enum logic [1:0] {IDLE, ARB, RD_WAIT, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             out_of_range;
  logic             ro_write;
  logic             grant;

  assign rf_addr    = {q_addr, addr};
  assign rf_wr_data = reg_data_held;

  always_comb begin
    out_of_range = (32'(addr) >= NUM_REGS_USED) || (32'(q_addr) >= NUM_OUTPUT_QUEUES);
    ro_write     = !reg_rd_wr_L_held && (32'(addr) < NUM_RO_REGS);
    grant        = (state == ARB) && !dp_busy && !out_of_range && !ro_write;
    rf_rd_en     = grant && reg_rd_wr_L_held;
    rf_wr_en     = grant && !reg_rd_wr_L_held;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      result_ready <= 1'b0;
      reg_result   <= '0;
      wait_cnt     <= '0;
    end else begin
      result_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (req_in_progress) begin
            state    <= ARB;
            wait_cnt <= '0;
          end
        end
        ARB: begin
          // Rejected requests never touch the port, so dp_busy is irrelevant for them.
          if (out_of_range) begin
            reg_result   <= BAD_ACCESS;
            result_ready <= 1'b1;
            state        <= DONE;
          end else if (ro_write) begin
            reg_result   <= '0;
            result_ready <= 1'b1;
            state        <= DONE;
          end else if (!dp_busy) begin
            if (reg_rd_wr_L_held) begin
              state <= RD_WAIT;
            end else begin
              reg_result   <= reg_data_held;
              result_ready <= 1'b1;
              state        <= DONE;
            end
          end else if (wait_cnt == CNT_W'(MAX_WAIT)) begin
            reg_result   <= BAD_ACCESS;
            result_ready <= 1'b1;
            state        <= DONE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        RD_WAIT: begin
          reg_result   <= rf_rd_data;
          result_ready <= 1'b1;
          state        <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oq_regs_host_proc.sv
// Randomized bench for oq_regs_host_proc against a cycle-count reference model of the access rules.
module tb_oq_regs_host_proc;

  localparam int NQ     = 8;
  localparam int NREGS  = 17;
  localparam int NRO    = 8;
  localparam int MAXW   = 255;
  localparam int MAXC   = 300;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_in_progress = 1'b0;
  logic        reg_rd_wr_L_held = 1'b0;
  logic [31:0] reg_data_held = '0;
  logic [4:0]  addr = '0;
  logic [2:0]  q_addr = '0;
  logic        result_ready;
  logic [31:0] reg_result;
  logic        dp_busy = 1'b0;
  logic        rf_rd_en;
  logic        rf_wr_en;
  logic [7:0]  rf_addr;
  logic [31:0] rf_wr_data;
  logic [31:0] rf_rd_data = '0;

  int n_checks = 0;
  int n_fail   = 0;
  bit busy_pat[0:MAXC];

  oq_regs_host_proc #(
    .NUM_OUTPUT_QUEUES(NQ),
    .NUM_OQ_WIDTH(3),
    .NUM_REGS_USED(NREGS),
    .ADDR_WIDTH(5),
    .NUM_RO_REGS(NRO),
    .MAX_WAIT(MAXW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .req_in_progress(req_in_progress),
    .reg_rd_wr_L_held(reg_rd_wr_L_held),
    .reg_data_held(reg_data_held),
    .addr(addr),
    .q_addr(q_addr),
    .result_ready(result_ready),
    .reg_result(reg_result),
    .dp_busy(dp_busy),
    .rf_rd_en(rf_rd_en),
    .rf_wr_en(rf_wr_en),
    .rf_addr(rf_addr),
    .rf_wr_data(rf_wr_data),
    .rf_rd_data(rf_rd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_busy();
    for (int i = 0; i <= MAXC; i++) busy_pat[i] = 1'b0;
  endtask

  // Reference: rejected requests finish in cycle 2; otherwise the first idle arbitration
  // cycle t (1..MAX_WAIT+1) strobes, reads finish at t+2, writes at t+1; else timeout.
  task automatic run_txn(input bit rd, input logic [2:0] q, input logic [4:0] a,
                         input logic [31:0] data, input logic [31:0] rval);
    int strobe;
    int done;
    logic [31:0] res;
    bit in_range;
    in_range = (int'(a) < NREGS) && (int'(q) < NQ);
    strobe = -1;
    if (!in_range) begin
      done = 2;
      res  = 32'hdead_beef;
    end else if (!rd && int'(a) < NRO) begin
      done = 2;
      res  = 32'h0;
    end else begin
      for (int t = 1; t <= MAXW + 1; t++) begin
        if (!busy_pat[t]) begin
          strobe = t;
          break;
        end
      end
      if (strobe < 0) begin
        done = MAXW + 2;
        res  = 32'hdead_beef;
      end else begin
        done = rd ? strobe + 2 : strobe + 1;
        res  = rd ? rval : data;
      end
    end

    @(posedge clk);
    #1;
    req_in_progress  = 1'b1;
    reg_rd_wr_L_held = rd;
    reg_data_held    = data;
    addr             = a;
    q_addr           = q;
    dp_busy          = busy_pat[0];
    rf_rd_data       = $urandom;
    for (int c = 0; c <= done + 1; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
        dp_busy    = busy_pat[c];
        rf_rd_data = (strobe >= 0 && c == strobe + 1) ? rval : $urandom;
        if (c == done + 1) req_in_progress = 1'b0;
      end
      @(negedge clk);
      check("ctl{rd,wr,ready}", {29'd0, rf_rd_en, rf_wr_en, result_ready},
            {29'd0, rd && c == strobe, !rd && c == strobe, c == done});
      if (c == strobe) begin
        check("rf_addr", {24'd0, rf_addr}, {24'd0, q, a});
        if (!rd) check("rf_wr_data", rf_wr_data, data);
      end
      if (c == done || c == done + 1) check("reg_result", reg_result, res);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    #12;
    check("rst_ctl", {29'd0, rf_rd_en, rf_wr_en, result_ready}, 32'd0);
    check("rst_result", reg_result, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    clear_busy();
    run_txn(1'b1, 3'd3, 5'd9, 32'h0, 32'h1234_5678);
    run_txn(1'b0, 3'd0, 5'd12, 32'hcafe_0001, 32'h0);
    run_txn(1'b0, 3'd5, 5'd2, 32'h5555_aaaa, 32'h0);
    for (int i = 1; i <= 5; i++) busy_pat[i] = 1'b1;
    run_txn(1'b1, 3'd7, 5'd16, 32'h0, 32'h0bad_f00d);
    clear_busy();
    for (int i = 0; i <= MAXC; i++) busy_pat[i] = 1'b1;
    run_txn(1'b1, 3'd1, 5'd10, 32'h0, 32'h7777_7777);
    run_txn(1'b0, 3'd1, 5'd10, 32'h8888_8888, 32'h0);
    clear_busy();
    run_txn(1'b1, 3'd2, 5'd17, 32'h0, 32'h1111_1111);
    run_txn(1'b0, 3'd2, 5'd31, 32'h2222_2222, 32'h0);
    run_txn(1'b0, 3'd4, 5'd8, 32'h3333_3333, 32'h0);

    // Reset pulsed while the read data is being captured.
    @(posedge clk);
    #1;
    req_in_progress  = 1'b1;
    reg_rd_wr_L_held = 1'b1;
    q_addr           = 3'd6;
    addr             = 5'd11;
    dp_busy          = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("abort_ctl", {29'd0, rf_rd_en, rf_wr_en, result_ready}, 32'd0);
    check("abort_result", reg_result, 32'd0);
    @(posedge clk);
    #1;
    req_in_progress = 1'b0;
    @(negedge clk);
    check("abort_hold", {29'd0, rf_rd_en, rf_wr_en, result_ready}, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    run_txn(1'b1, 3'd6, 5'd11, 32'h0, 32'hfeed_0042);

    for (int n = 0; n < 60; n++) begin
      int mode;
      int k;
      mode = $urandom_range(0, 3);
      clear_busy();
      case (mode)
        1: for (int i = 0; i <= MAXC; i++) busy_pat[i] = ($urandom_range(0, 3) == 0);
        2: begin
          k = $urandom_range(1, 20);
          for (int i = 1; i <= k; i++) busy_pat[i] = 1'b1;
        end
        3: for (int i = 0; i <= MAXC; i++) busy_pat[i] = ($urandom_range(0, 4) < 3);
        default: ;
      endcase
      run_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
              $urandom, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
